// File: rtl/pool_fc_flatten_pkg.sv
// Shared constants, state encoding and config check for the pooling-to-FC flatten stage.
// The default sizes are also used by the CNN top level.
package pool_fc_flatten_pkg;

    localparam int DEF_ELEM_WIDTH     = 8;
    localparam int DEF_MAX_IMG_HEIGHT = 32;
    localparam int DEF_MAX_IMG_WIDTH  = 32;
    localparam int DEF_MAX_CHANNELS   = 16;
    localparam int DEF_INPUT_SIZE     = 128;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_MAP = 3'd1,
        ST_COPY     = 3'd2,
        ST_LAUNCH   = 3'd3,
        ST_WAIT_FC  = 3'd4
    } state_t;

    // A frame needs non-empty maps and must fit inside the hardware maxima.
    function automatic logic cfgIsValid(input logic [7:0] h, input logic [7:0] w,
                                        input logic [7:0] c, input int maxH,
                                        input int maxW, input int maxC);
        return (h != 8'd0) && (w != 8'd0) && (c != 8'd0) &&
               (int'(h) <= maxH) && (int'(w) <= maxW) && (int'(c) <= maxC);
    endfunction

endpackage

// File: rtl/pool_fc_flatten_if.sv
// Map-input and FC-output handshake bundle of the flatten stage.
// The master modport is the side that feeds maps and reports FC completion.
interface pool_fc_flatten_if
    import pool_fc_flatten_pkg::*;
#(
    parameter int ELEM_WIDTH     = DEF_ELEM_WIDTH,
    parameter int MAX_IMG_HEIGHT = DEF_MAX_IMG_HEIGHT,
    parameter int MAX_IMG_WIDTH  = DEF_MAX_IMG_WIDTH,
    parameter int INPUT_SIZE     = DEF_INPUT_SIZE
) ();

    logic                                          mapValid;
    logic [MAX_IMG_HEIGHT*MAX_IMG_WIDTH*ELEM_WIDTH-1:0] mapData;
    logic                                          mapReady;
    logic                                          fcEn;
    logic [INPUT_SIZE*ELEM_WIDTH-1:0]              fcInVec;
    logic                                          fcValid;

    modport master (output mapValid, mapData, fcValid, input mapReady, fcEn, fcInVec);
    modport slave  (input mapValid, mapData, fcValid, output mapReady, fcEn, fcInVec);

endinterface

// File: rtl/pool_fc_flatten_fmap_elem_select.sv
// Combinational (row, col) element pick from a registered feature map.
// Rows are laid out with a stride of MAX_IMG_WIDTH regardless of the active width.
module fmap_elem_select
    import pool_fc_flatten_pkg::*;
#(
    parameter int ELEM_WIDTH     = DEF_ELEM_WIDTH,
    parameter int MAX_IMG_HEIGHT = DEF_MAX_IMG_HEIGHT,
    parameter int MAX_IMG_WIDTH  = DEF_MAX_IMG_WIDTH,
    parameter int ROW_W          = 5,
    parameter int COL_W          = 5
) (
    input  logic [MAX_IMG_HEIGHT*MAX_IMG_WIDTH*ELEM_WIDTH-1:0] i_map,
    input  logic [ROW_W-1:0]                                   i_row,
    input  logic [COL_W-1:0]                                   i_col,
    output logic [ELEM_WIDTH-1:0]                              o_elem
);

    assign o_elem = i_map[(int'(i_row) * MAX_IMG_WIDTH + int'(i_col)) * ELEM_WIDTH +: ELEM_WIDTH];

endmodule

// File: rtl/pool_fc_flatten.sv
// Collects pooled feature maps, flattens them channel-major into the FC input vector,
// launches the FC layer with a one-cycle enable and waits for its completion.
module pool_fc_flatten
    import pool_fc_flatten_pkg::*;
#(
    parameter int ELEM_WIDTH     = DEF_ELEM_WIDTH,
    parameter int MAX_IMG_HEIGHT = DEF_MAX_IMG_HEIGHT,
    parameter int MAX_IMG_WIDTH  = DEF_MAX_IMG_WIDTH,
    parameter int MAX_CHANNELS   = DEF_MAX_CHANNELS,
    parameter int INPUT_SIZE     = DEF_INPUT_SIZE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [7:0]       i_cfg_map_height,
    input  logic [7:0]       i_cfg_map_width,
    input  logic [7:0]       i_cfg_channels,
    pool_fc_flatten_if.slave io_bus,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err_cfg,
    output logic             o_err_overflow
);

    localparam int ROW_W    = (MAX_IMG_HEIGHT > 1) ? $clog2(MAX_IMG_HEIGHT) : 1;
    localparam int COL_W    = (MAX_IMG_WIDTH > 1) ? $clog2(MAX_IMG_WIDTH) : 1;
    localparam int CH_W     = (MAX_CHANNELS > 1) ? $clog2(MAX_CHANNELS) : 1;
    localparam int IDX_W    = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
    localparam int PTR_W    = $clog2(MAX_CHANNELS * MAX_IMG_HEIGHT * MAX_IMG_WIDTH + INPUT_SIZE + 1);
    localparam int MAP_BITS = MAX_IMG_HEIGHT * MAX_IMG_WIDTH * ELEM_WIDTH;
    localparam int VEC_BITS = INPUT_SIZE * ELEM_WIDTH;

    state_t                r_state;
    state_t                w_nextState;
    logic [ROW_W-1:0]      r_lastRow;
    logic [ROW_W-1:0]      r_row;
    logic [COL_W-1:0]      r_lastCol;
    logic [COL_W-1:0]      r_col;
    logic [CH_W-1:0]       r_lastCh;
    logic [CH_W-1:0]       r_chCnt;
    logic [PTR_W-1:0]      r_wrPtr;
    logic [MAP_BITS-1:0]   r_map;
    logic [VEC_BITS-1:0]   r_buf;
    logic                  r_done;
    logic                  r_errCfg;
    logic                  r_errOvf;
    logic                  w_cfgOk;
    logic                  w_lastElem;
    logic                  w_inRange;
    logic [IDX_W-1:0]      w_wrIdx;
    logic [ELEM_WIDTH-1:0] w_elem;

    assign w_cfgOk    = cfgIsValid(i_cfg_map_height, i_cfg_map_width, i_cfg_channels,
                                   MAX_IMG_HEIGHT, MAX_IMG_WIDTH, MAX_CHANNELS);
    assign w_lastElem = (r_row == r_lastRow) && (r_col == r_lastCol);
    assign w_inRange  = (r_wrPtr < PTR_W'(INPUT_SIZE));
    assign w_wrIdx    = IDX_W'(r_wrPtr);

    fmap_elem_select #(
        .ELEM_WIDTH     (ELEM_WIDTH),
        .MAX_IMG_HEIGHT (MAX_IMG_HEIGHT),
        .MAX_IMG_WIDTH  (MAX_IMG_WIDTH),
        .ROW_W          (ROW_W),
        .COL_W          (COL_W)
    ) u_elemSelect (
        .i_map  (r_map),
        .i_row  (r_row),
        .i_col  (r_col),
        .o_elem (w_elem)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_nextState;
    end

    always_comb begin
        w_nextState     = r_state;
        io_bus.mapReady = 1'b0;
        io_bus.fcEn     = 1'b0;
        o_busy          = (r_state != ST_IDLE);
        unique case (r_state)
            ST_IDLE:     if (i_start && w_cfgOk) w_nextState = ST_WAIT_MAP;
            ST_WAIT_MAP: begin
                io_bus.mapReady = 1'b1;
                if (io_bus.mapValid) w_nextState = ST_COPY;
            end
            ST_COPY:     if (w_lastElem) w_nextState = (r_chCnt == r_lastCh) ? ST_LAUNCH : ST_WAIT_MAP;
            ST_LAUNCH: begin
                io_bus.fcEn = 1'b1;
                w_nextState = ST_WAIT_FC;
            end
            ST_WAIT_FC:  if (io_bus.fcValid) w_nextState = ST_IDLE;
            default:     w_nextState = ST_IDLE;
        endcase
    end

    // Overflowing elements still advance the write pointer so later writes stay dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lastRow <= '0;
            r_lastCol <= '0;
            r_lastCh  <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_chCnt   <= '0;
            r_wrPtr   <= '0;
            r_map     <= '0;
            r_buf     <= '0;
            r_done    <= 1'b0;
            r_errCfg  <= 1'b0;
            r_errOvf  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        if (w_cfgOk) begin
                            r_lastRow <= ROW_W'(i_cfg_map_height - 8'd1);
                            r_lastCol <= COL_W'(i_cfg_map_width - 8'd1);
                            r_lastCh  <= CH_W'(i_cfg_channels - 8'd1);
                            r_chCnt   <= '0;
                            r_wrPtr   <= '0;
                            r_buf     <= '0;
                            r_errCfg  <= 1'b0;
                            r_errOvf  <= 1'b0;
                        end else begin
                            r_errCfg  <= 1'b1;
                        end
                    end
                end
                ST_WAIT_MAP: begin
                    if (io_bus.mapValid) begin
                        r_map <= io_bus.mapData;
                        r_row <= '0;
                        r_col <= '0;
                    end
                end
                ST_COPY: begin
                    if (w_inRange) r_buf[w_wrIdx * ELEM_WIDTH +: ELEM_WIDTH] <= w_elem;
                    else           r_errOvf <= 1'b1;
                    r_wrPtr <= r_wrPtr + 1'b1;
                    if (r_col == r_lastCol) begin
                        r_col <= '0;
                        r_row <= r_row + 1'b1;
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                    if (w_lastElem && (r_chCnt != r_lastCh)) r_chCnt <= r_chCnt + 1'b1;
                end
                ST_WAIT_FC: begin
                    if (io_bus.fcValid) r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign io_bus.fcInVec = r_buf;
    assign o_done         = r_done;
    assign o_err_cfg      = r_errCfg;
    assign o_err_overflow = r_errOvf;

endmodule

// File: tb/tb_pool_fc_flatten.sv
// Directed self-checking bench for pool_fc_flatten: basic frame with backpressure,
// ignored events, overflow, config error and asynchronous reset mid-copy.
module tb_pool_fc_flatten;
    import pool_fc_flatten_pkg::*;

    localparam int MAP_BITS = DEF_MAX_IMG_HEIGHT * DEF_MAX_IMG_WIDTH * DEF_ELEM_WIDTH;
    localparam int VEC_BITS = DEF_INPUT_SIZE * DEF_ELEM_WIDTH;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] cfgH;
    logic [7:0] cfgW;
    logic [7:0] cfgC;
    logic       busy;
    logic       done;
    logic       errCfg;
    logic       errOvf;

    int checks   = 0;
    int failures = 0;

    pool_fc_flatten_if bus ();

    pool_fc_flatten dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_start          (start),
        .i_cfg_map_height (cfgH),
        .i_cfg_map_width  (cfgW),
        .i_cfg_channels   (cfgC),
        .io_bus           (bus),
        .o_busy           (busy),
        .o_done           (done),
        .o_err_cfg        (errCfg),
        .o_err_overflow   (errOvf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Scalar comparison with failure count and report.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Whole-vector comparison; the report names the first differing element.
    task automatic checkVector(input string tag, input logic [VEC_BITS-1:0] observed,
                               input logic [VEC_BITS-1:0] expected);
        int firstBad = -1;
        for (int i = DEF_INPUT_SIZE - 1; i >= 0; i--)
            if (observed[i*8 +: 8] !== expected[i*8 +: 8]) firstBad = i;
        if (firstBad < 0) firstBad = 0;
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s elem[%0d] observed=%0h expected=%0h", tag, firstBad,
                   observed[firstBad*8 +: 8], expected[firstBad*8 +: 8]);
        end
    endtask

    // Pulses start for one cycle with the given configuration.
    task automatic applyStimulus(input logic [7:0] h, input logic [7:0] w, input logic [7:0] c);
        start = 1'b1;
        cfgH  = h;
        cfgW  = w;
        cfgC  = c;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Holds a map valid until accepted; returns the number of cycles spent stalled.
    task automatic sendMap(input logic [MAP_BITS-1:0] m, output int stalls);
        stalls       = 0;
        bus.mapData  = m;
        bus.mapValid = 1'b1;
        while (!bus.mapReady && stalls < 200) begin
            @(negedge clk);
            stalls++;
        end
        checkOutput("map_ready_seen", 64'(bus.mapReady), 64'd1);
        @(negedge clk);
        bus.mapValid = 1'b0;
    endtask

    // Called in the cycle after the last handshake; counts cycles from that handshake to fc_en.
    task automatic waitFcEn(output int lat);
        lat = 1;
        while (!bus.fcEn && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    function automatic logic [MAP_BITS-1:0] mk2x2(input logic [7:0] b0, input logic [7:0] b1,
                                                  input logic [7:0] b2, input logic [7:0] b3);
        logic [MAP_BITS-1:0] m;
        m = '0;
        for (int i = 0; i < MAP_BITS / 8; i++) m[i*8 +: 8] = 8'hEE;
        m[(0*32+0)*8 +: 8] = b0;
        m[(0*32+1)*8 +: 8] = b1;
        m[(1*32+0)*8 +: 8] = b2;
        m[(1*32+1)*8 +: 8] = b3;
        return m;
    endfunction

    // Element (r,c) of channel ch carries ch*64 + r*w + c; unused positions carry EE.
    function automatic logic [MAP_BITS-1:0] mkMap(input int h, input int w, input int ch);
        logic [MAP_BITS-1:0] m;
        m = '0;
        for (int i = 0; i < MAP_BITS / 8; i++) m[i*8 +: 8] = 8'hEE;
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                m[(r*32+c)*8 +: 8] = 8'((ch << 6) | (r*w + c));
        return m;
    endfunction

    initial begin
        logic [VEC_BITS-1:0] expVec;
        int stalls;
        int lat;

        rst_n        = 1'b0;
        start        = 1'b0;
        cfgH         = 8'd0;
        cfgW         = 8'd0;
        cfgC         = 8'd0;
        bus.mapValid = 1'b0;
        bus.mapData  = '0;
        bus.fcValid  = 1'b0;
        repeat (3) @(negedge clk);

        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_map_ready", 64'(bus.mapReady), 64'd0);
        checkOutput("rst_fc_en", 64'(bus.fcEn), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_err_cfg", 64'(errCfg), 64'd0);
        checkOutput("rst_err_ovf", 64'(errOvf), 64'd0);
        checkVector("rst_vec", bus.fcInVec, '0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle_busy", 64'(busy), 64'd0);

        $display("[TB] basic frame H=2 W=2 C=2 with backpressure on map1");
        applyStimulus(8'd2, 8'd2, 8'd2);
        checkOutput("basic_busy", 64'(busy), 64'd1);
        checkOutput("basic_map_ready", 64'(bus.mapReady), 64'd1);
        sendMap(mk2x2(8'h01, 8'h02, 8'h03, 8'h04), stalls);
        checkOutput("map0_stalls", 64'(stalls), 64'd0);
        sendMap(mk2x2(8'hFF, 8'h05, 8'h06, 8'h07), stalls);
        checkOutput("map1_stalls", 64'(stalls), 64'd4);
        waitFcEn(lat);
        checkOutput("basic_fc_en_latency", 64'(lat), 64'd5);
        expVec = '0;
        expVec[63:0] = 64'h0706_05FF_0403_0201;
        checkVector("basic_vec", bus.fcInVec, expVec);
        @(negedge clk);
        checkOutput("basic_fc_en_one_cycle", 64'(bus.fcEn), 64'd0);
        checkOutput("wait_fc_busy", 64'(busy), 64'd1);

        $display("[TB] start during WAIT_FC is ignored");
        applyStimulus(8'd1, 8'd1, 8'd1);
        checkOutput("wait_fc_start_busy", 64'(busy), 64'd1);
        checkOutput("wait_fc_start_ready", 64'(bus.mapReady), 64'd0);
        checkVector("wait_fc_start_vec", bus.fcInVec, expVec);
        bus.fcValid = 1'b1;
        @(negedge clk);
        bus.fcValid = 1'b0;
        checkOutput("basic_done", 64'(done), 64'd1);
        checkOutput("basic_done_busy", 64'(busy), 64'd0);
        @(negedge clk);
        checkOutput("basic_done_pulse", 64'(done), 64'd0);
        checkVector("basic_vec_held", bus.fcInVec, expVec);

        $display("[TB] overflow frame H=8 W=8 C=3");
        applyStimulus(8'd8, 8'd8, 8'd3);
        checkVector("ovf_start_clears_vec", bus.fcInVec, '0);
        bus.fcValid = 1'b1;
        @(negedge clk);
        bus.fcValid = 1'b0;
        checkOutput("fc_valid_in_wait_map_busy", 64'(busy), 64'd1);
        checkOutput("fc_valid_in_wait_map_ready", 64'(bus.mapReady), 64'd1);
        checkOutput("fc_valid_in_wait_map_done", 64'(done), 64'd0);
        sendMap(mkMap(8, 8, 0), stalls);
        sendMap(mkMap(8, 8, 1), stalls);
        checkOutput("ovf_no_err_mid", 64'(errOvf), 64'd0);
        sendMap(mkMap(8, 8, 2), stalls);
        waitFcEn(lat);
        checkOutput("ovf_fc_en_latency", 64'(lat), 64'd65);
        checkOutput("ovf_err", 64'(errOvf), 64'd1);
        for (int i = 0; i < DEF_INPUT_SIZE; i++) expVec[i*8 +: 8] = 8'(i);
        checkVector("ovf_vec", bus.fcInVec, expVec);
        @(negedge clk);
        checkOutput("ovf_fc_en_one_cycle", 64'(bus.fcEn), 64'd0);
        bus.fcValid = 1'b1;
        @(negedge clk);
        bus.fcValid = 1'b0;
        checkOutput("ovf_done", 64'(done), 64'd1);
        checkOutput("ovf_err_sticky", 64'(errOvf), 64'd1);

        $display("[TB] config error C=0");
        applyStimulus(8'd2, 8'd2, 8'd0);
        checkOutput("cfg_err", 64'(errCfg), 64'd1);
        checkOutput("cfg_err_busy", 64'(busy), 64'd0);
        checkOutput("cfg_err_ready", 64'(bus.mapReady), 64'd0);
        checkOutput("cfg_err_keeps_ovf", 64'(errOvf), 64'd1);
        applyStimulus(8'd33, 8'd1, 8'd1);
        checkOutput("cfg_err_h_too_big_busy", 64'(busy), 64'd0);
        applyStimulus(8'd1, 8'd1, 8'd1);
        checkOutput("cfg_ok_clears_err", 64'(errCfg), 64'd0);
        checkOutput("cfg_ok_clears_ovf", 64'(errOvf), 64'd0);
        checkOutput("cfg_ok_busy", 64'(busy), 64'd1);
        checkVector("cfg_ok_clears_vec", bus.fcInVec, '0);
        sendMap(mk2x2(8'h5A, 8'h11, 8'h22, 8'h33), stalls);
        waitFcEn(lat);
        checkOutput("one_elem_fc_en_latency", 64'(lat), 64'd2);
        expVec = '0;
        expVec[7:0] = 8'h5A;
        checkVector("one_elem_vec", bus.fcInVec, expVec);
        @(negedge clk);
        bus.fcValid = 1'b1;
        @(negedge clk);
        bus.fcValid = 1'b0;
        checkOutput("one_elem_done", 64'(done), 64'd1);

        $display("[TB] asynchronous reset during COPY");
        applyStimulus(8'd4, 8'd4, 8'd1);
        sendMap(mkMap(4, 4, 1), stalls);
        @(negedge clk);
        checkOutput("pre_rst_busy", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_busy", 64'(busy), 64'd0);
        checkOutput("async_rst_fc_en", 64'(bus.fcEn), 64'd0);
        checkOutput("async_rst_ready", 64'(bus.mapReady), 64'd0);
        checkVector("async_rst_vec", bus.fcInVec, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_busy", 64'(busy), 64'd0);
        checkOutput("post_rst_ready", 64'(bus.mapReady), 64'd0);
        checkOutput("post_rst_done", 64'(done), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
